// File: rtl/route_sequencer.sv
// route_sequencer: walks a programmable route table, issuing one route_req/pwm_go per
// entry to the motor controller, then waiting for task_done under a per-step timeout.

module route_sequencer #(
   parameter int          DEPTH   = 16,
   parameter int          AW      = 4,
   parameter int          SETTLE  = 4,
   parameter int unsigned TIMEOUT = 500_000_000
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          abort,
   input  logic          prog_we,
   input  logic [AW-1:0] prog_addr,
   input  logic [2:0]    prog_data,
   input  logic          task_done,
   output logic [2:0]    route_req,
   output logic          pwm_go,
   output logic          busy,
   output logic          done,
   output logic          error,
   output logic [AW-1:0] step_idx
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_FETCH  = 3'd1;
   localparam logic [2:0] ST_ISSUE  = 3'd2;
   localparam logic [2:0] ST_SETTLE = 3'd3;
   localparam logic [2:0] ST_WAIT   = 3'd4;
   localparam logic [2:0] ST_NEXT   = 3'd5;
   localparam logic [2:0] ST_DONE   = 3'd6;
   localparam logic [2:0] ST_FAULT  = 3'd7;

   localparam logic [31:0]   SETTLE_LAST  = 32'(SETTLE - 1);
   localparam logic [31:0]   TIMEOUT_LAST = TIMEOUT - 32'd1;
   localparam logic [AW-1:0] LAST_IDX     = AW'(DEPTH - 1);

   logic [2:0]    state_q, state_d;
   logic [2:0]    route_req_q, route_req_d;
   logic          pwm_go_q, pwm_go_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          error_q, error_d;
   logic [AW-1:0] step_idx_q, step_idx_d;
   logic [31:0]   cnt_q, cnt_d;
   logic          stop_pend_q, stop_pend_d;
   logic [2:0]    route_tbl_q [DEPTH];
   logic [2:0]    route_tbl_d [DEPTH];

   logic          busy_now;
   logic          want_stop;
   logic [2:0]    code;

   assign busy_now = (state_q == ST_FETCH) || (state_q == ST_ISSUE) || (state_q == ST_SETTLE) ||
                     (state_q == ST_WAIT) || (state_q == ST_NEXT);
   assign code     = route_tbl_q[step_idx_q];

   always_comb begin
      route_tbl_d = route_tbl_q;
      if (prog_we && !busy_now) begin
         route_tbl_d[prog_addr] = prog_data;
      end
   end

   always_comb begin
      state_d     = state_q;
      route_req_d = route_req_q;
      step_idx_d  = step_idx_q;
      cnt_d       = cnt_q;
      want_stop   = 1'b0;
      if (abort) begin
         state_d     = ST_IDLE;
         route_req_d = 3'b000;
         want_stop   = busy_now;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_d    = ST_FETCH;
                  step_idx_d = '0;
               end
            end
            ST_FETCH: begin
               if (code == 3'b000) begin
                  state_d     = ST_DONE;
                  route_req_d = 3'b000;
                  want_stop   = 1'b1;
               end else begin
                  state_d = ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               route_req_d = code;
               cnt_d       = '0;
               state_d     = ST_SETTLE;
            end
            ST_SETTLE: begin
               if (cnt_q == SETTLE_LAST) begin
                  state_d = ST_WAIT;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 32'd1;
               end
            end
            ST_WAIT: begin
               // completion wins over a timeout expiring in the same cycle
               if (task_done) begin
                  state_d = ST_NEXT;
               end else if (cnt_q == TIMEOUT_LAST) begin
                  state_d     = ST_FAULT;
                  route_req_d = 3'b000;
                  want_stop   = 1'b1;
               end else begin
                  cnt_d = cnt_q + 32'd1;
               end
            end
            ST_NEXT: begin
               if (step_idx_q == LAST_IDX) begin
                  state_d     = ST_DONE;
                  route_req_d = 3'b000;
                  want_stop   = 1'b1;
               end else begin
                  step_idx_d = step_idx_q + 1'b1;
                  state_d    = ST_FETCH;
               end
            end
            ST_DONE, ST_FAULT: begin
               if (start) begin
                  state_d    = ST_FETCH;
                  step_idx_d = '0;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
      // a stop pulse that would abut the previous pwm_go is held back one cycle
      pwm_go_d    = (!abort && (state_q == ST_ISSUE)) || ((want_stop || stop_pend_q) && !pwm_go_q);
      stop_pend_d = (want_stop || stop_pend_q) && pwm_go_q;
      busy_d      = (state_d == ST_FETCH) || (state_d == ST_ISSUE) || (state_d == ST_SETTLE) ||
                    (state_d == ST_WAIT) || (state_d == ST_NEXT);
      done_d      = (state_d == ST_DONE);
      error_d     = (state_d == ST_FAULT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         route_req_q <= 3'b000;
         pwm_go_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         step_idx_q  <= '0;
         cnt_q       <= '0;
         stop_pend_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            route_tbl_q[i] <= 3'b000;
         end
      end else begin
         state_q     <= state_d;
         route_req_q <= route_req_d;
         pwm_go_q    <= pwm_go_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
         step_idx_q  <= step_idx_d;
         cnt_q       <= cnt_d;
         stop_pend_q <= stop_pend_d;
         route_tbl_q <= route_tbl_d;
      end
   end

   assign route_req = route_req_q;
   assign pwm_go    = pwm_go_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign error     = error_q;
   assign step_idx  = step_idx_q;

endmodule

// File: tb/tb_route_sequencer.sv
// Bench for route_sequencer: directed scenarios plus randomized route tables, with expected
// pulse timing derived from a step-level timing model of the sequencer.

module tb_route_sequencer;

   localparam int DEPTH   = 16;
   localparam int AW      = 4;
   localparam int SETTLE  = 4;
   localparam int TIMEOUT = 100;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          prog_we = 1'b0;
   logic [AW-1:0] prog_addr = '0;
   logic [2:0]    prog_data = 3'b000;
   logic          task_done;
   logic [2:0]    route_req;
   logic          pwm_go, busy, done, error;
   logic [AW-1:0] step_idx;

   logic td_resp = 1'b0;
   logic td_force = 1'b0;
   logic hold_hi = 1'b0;
   assign task_done = td_resp | td_force;

   route_sequencer #(.DEPTH(DEPTH), .AW(AW), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .prog_we(prog_we),
      .prog_addr(prog_addr), .prog_data(prog_data), .task_done(task_done),
      .route_req(route_req), .pwm_go(pwm_go), .busy(busy), .done(done), .error(error),
      .step_idx(step_idx)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   int mtbl [DEPTH];
   int dly [64];
   int pn = 0;
   int rise_at = 1 << 30;
   int gc [$];
   int gk [$];
   int ec [$];
   int ek [$];
   int m_idx, m_done, m_err;

   // motor-controller stand-in: logs every pwm_go and raises task_done dly[n] cycles later
   always @(negedge clk) begin
      if (pwm_go) begin
         gc.push_back(cyc);
         gk.push_back(int'(route_req));
         rise_at = cyc + dly[pn];
         if (pn < 63) pn++;
         td_resp = hold_hi;
      end else begin
         td_resp = hold_hi || (cyc >= rise_at);
      end
   end

   initial begin
      #900_000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic write_table();
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clk);
         prog_we   = 1'b1;
         prog_addr = AW'(i);
         prog_data = 3'(mtbl[i]);
      end
      @(negedge clk);
      prog_we = 1'b0;
   endtask

   // Expected (cycle, code) of every pwm_go for a route started in cycle c.
   task automatic model(input int c);
      int t, p, idx, n, d, w;
      bit fin;
      ec.delete();
      ek.delete();
      idx = 0; n = 0; t = c + 1; fin = 0; m_done = 0; m_err = 0;
      while (!fin) begin
         if (mtbl[idx] == 0) begin
            ec.push_back(t + 1); ek.push_back(0); m_done = 1; fin = 1;
         end else begin
            p = t + 2;
            ec.push_back(p); ek.push_back(mtbl[idx]);
            d = hold_hi ? 0 : dly[n];
            n++;
            if (d >= SETTLE + TIMEOUT) begin
               ec.push_back(p + SETTLE + TIMEOUT); ek.push_back(0); m_err = 1; fin = 1;
            end else begin
               w = (d > SETTLE) ? p + d : p + SETTLE;
               if (idx == DEPTH - 1) begin
                  ec.push_back(w + 2); ek.push_back(0); m_done = 1; fin = 1;
               end else begin
                  idx++;
                  t = w + 2;
               end
            end
         end
      end
      m_idx = idx;
   endtask

   task automatic run_route(input string tag, input bit meddle);
      int c, n, dc;
      gc.delete(); gk.delete();
      pn = 0; rise_at = 1 << 30;
      @(negedge clk);
      c = cyc;
      start = 1'b1;
      model(c);
      @(negedge clk);
      start = 1'b0;
      if (meddle) begin
         prog_we = 1'b1; prog_addr = '0; prog_data = 3'b111; start = 1'b1;
         repeat (3) @(negedge clk);
         prog_we = 1'b0; start = 1'b0;
      end
      n = 0;
      while (n < 4000 && !(done || error)) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_finished"}, 32'(n < 4000), 1);
      dc = cyc;
      repeat (4) @(negedge clk);
      chk({tag, "_npulse"}, gc.size(), ec.size());
      for (int i = 0; i < gc.size() && i < ec.size(); i++) begin
         chk($sformatf("%s_p%0d_cyc", tag, i), gc[i], ec[i]);
         chk($sformatf("%s_p%0d_code", tag, i), gk[i], ek[i]);
      end
      for (int i = 1; i < gc.size(); i++) begin
         chk($sformatf("%s_gap%0d", tag, i), 32'(gc[i] - gc[i-1] > 1), 1);
      end
      chk({tag, "_endcyc"}, dc, ec[ec.size()-1]);
      chk({tag, "_done"}, done, m_done);
      chk({tag, "_error"}, error, m_err);
      chk({tag, "_idx"}, step_idx, m_idx);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_req"}, route_req, 0);
   endtask

   initial begin
      int n;
      for (int i = 0; i < DEPTH; i++) mtbl[i] = 0;
      for (int i = 0; i < 64; i++) dly[i] = 10;
      repeat (3) @(negedge clk);
      chk("rst_req", route_req, 0);
      chk("rst_pwm", pwm_go, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      chk("rst_idx", step_idx, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // three routes then STOP, task_done 10 cycles after each pulse
      mtbl[0] = 1; mtbl[1] = 3; mtbl[2] = 5; mtbl[3] = 0;
      write_table();
      run_route("t2", 0);

      // abort together with start while DONE: abort wins, lands in IDLE without a pulse
      @(negedge clk);
      abort = 1'b1; start = 1'b1;
      @(negedge clk);
      abort = 1'b0; start = 1'b0;
      chk("abort_done_done", done, 0);
      chk("abort_done_busy", busy, 0);
      chk("abort_done_pwm", pwm_go, 0);
      @(negedge clk);
      chk("abort_done_idle", busy, 0);
      chk("abort_done_pwm2", pwm_go, 0);

      // task_done held high the whole time
      hold_hi = 1'b1;
      mtbl[0] = 2; mtbl[1] = 0; mtbl[2] = 0;
      write_table();
      run_route("t3", 0);
      mtbl[1] = 2;
      write_table();
      run_route("t3b", 0);
      chk("t3b_spacing", gc[1] - gc[0], SETTLE + 4);
      hold_hi = 1'b0;

      // timeout, then completion on the very last WAIT cycle, then timeout by one cycle
      mtbl[0] = 4; mtbl[1] = 0;
      write_table();
      dly[0] = 1000;
      run_route("t4", 0);
      dly[0] = SETTLE + TIMEOUT - 1;
      run_route("t4_edge_ok", 0);
      dly[0] = SETTLE + TIMEOUT;
      run_route("t4_edge_to", 0);
      dly[0] = 10;
      run_route("t4_clear", 0);

      // abort coinciding with task_done in WAIT of step 2
      for (int i = 0; i < DEPTH; i++) mtbl[i] = (i < 4) ? 1 : 0;
      write_table();
      dly[0] = 5; dly[1] = 5; dly[2] = 60;
      gc.delete(); gk.delete(); pn = 0; rise_at = 1 << 30;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      n = 0;
      while (n < 500 && gc.size() < 3) begin @(negedge clk); n++; end
      chk("t5_reach_step2", 32'(n < 500), 1);
      repeat (12) @(negedge clk);
      chk("t5_in_wait_busy", busy, 1);
      abort = 1'b1; td_force = 1'b1;
      @(negedge clk);
      abort = 1'b0; td_force = 1'b0;
      chk("t5_busy", busy, 0);
      chk("t5_req", route_req, 0);
      chk("t5_pwm", pwm_go, 1);
      chk("t5_done", done, 0);
      repeat (8) @(negedge clk);
      chk("t5_npulse", gc.size(), 4);
      chk("t5_last_code", gk[gk.size()-1], 0);
      chk("t5_idle", busy, 0);

      // abort in the very cycle pwm_go is high: stop pulse must not abut it
      mtbl[0] = 6; mtbl[1] = 0;
      write_table();
      dly[0] = 20;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      n = 0;
      while (n < 20 && !pwm_go) begin @(negedge clk); n++; end
      chk("abp_pulse_seen", 32'(n < 20), 1);
      chk("abp_pulse_code", route_req, 6);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abp_no_b2b", pwm_go, 0);
      chk("abp_busy", busy, 0);
      chk("abp_req", route_req, 0);
      @(negedge clk);
      chk("abp_stop_pulse", pwm_go, 1);
      chk("abp_stop_req", route_req, 0);
      @(negedge clk);
      chk("abp_single", pwm_go, 0);

      // full table, writes and starts while busy are ignored
      for (int i = 0; i < DEPTH; i++) mtbl[i] = $urandom_range(7, 1);
      mtbl[0] = 3;
      write_table();
      for (int i = 0; i < 64; i++) dly[i] = $urandom_range(20, 1);
      run_route("t6", 1);
      for (int i = 0; i < 64; i++) dly[i] = $urandom_range(20, 1);
      run_route("t6_again", 0);

      // randomized tables, delays and occasional timeouts
      for (int r = 0; r < 4; r++) begin
         int pos;
         for (int i = 0; i < DEPTH; i++) mtbl[i] = $urandom_range(7, 1);
         pos = $urandom_range(16, 1);
         if (pos < DEPTH) mtbl[pos] = 0;
         for (int i = 0; i < 64; i++) dly[i] = ($urandom_range(11, 0) == 0) ? 1000 : $urandom_range(30, 1);
         write_table();
         run_route($sformatf("rnd%0d", r), 0);
      end

      // reset in the middle of WAIT clears everything including the table
      for (int i = 0; i < DEPTH; i++) mtbl[i] = 5;
      write_table();
      dly[0] = 80;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (12) @(negedge clk);
      chk("t1_pre_busy", busy, 1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("t1_req", route_req, 0);
      chk("t1_pwm", pwm_go, 0);
      chk("t1_busy", busy, 0);
      chk("t1_done", done, 0);
      chk("t1_error", error, 0);
      chk("t1_idx", step_idx, 0);
      rst_n = 1'b1;
      for (int i = 0; i < DEPTH; i++) mtbl[i] = 0;
      run_route("t1_empty", 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
